// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian 32-bit words from a byte stream, writes them to
// instruction memory from address 0 and holds the core in reset until the last word lands.
module imem_loader #(
    parameter int ADDR_W     = 4,
    parameter int WORD_COUNT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    input  logic              Restart,
    output logic              ImWrEn,
    output logic [ADDR_W-1:0] ImWrAddr,
    output logic [31:0]       ImWrData,
    output logic              CpuRst,
    output logic              Done
);

    // state   | meaning
    // S_LOAD  | accepting bytes into the assembly register
    // S_WRITE | one-cycle write strobe of the assembled word
    // S_DONE  | load complete, core released, input ignored
    typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       asm_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_LOAD;
            byte_cnt  <= 2'd0;
            word_addr <= '0;
            asm_reg   <= 32'd0;
        end else if (Restart) begin
            state     <= S_LOAD;
            byte_cnt  <= 2'd0;
            word_addr <= '0;
            asm_reg   <= 32'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (ByteValid) begin
                        case (byte_cnt)
                            2'd0:    asm_reg[31:24] <= ByteIn;
                            2'd1:    asm_reg[23:16] <= ByteIn;
                            2'd2:    asm_reg[15:8]  <= ByteIn;
                            default: asm_reg[7:0]   <= ByteIn;
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // the last word parks the address instead of wrapping
                    if (word_addr == LAST_ADDR) begin
                        state <= S_DONE;
                    end else begin
                        word_addr <= word_addr + 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // outputs decode purely from registered state, so reset clears them immediately
    assign ByteReady = (state == S_LOAD);
    assign ImWrEn    = (state == S_WRITE);
    assign ImWrAddr  = word_addr;
    assign ImWrData  = asm_reg;
    assign CpuRst    = (state != S_DONE);
    assign Done      = (state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random/directed byte streams scored against a word-level
// reference model, plus a single-word build checked directly.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        restart = 1'b0;
    logic        byte_ready;
    logic        im_wr_en;
    logic [3:0]  im_wr_addr;
    logic [31:0] im_wr_data;
    logic        cpu_rst;
    logic        done;

    logic [7:0]  b1_in = 8'd0;
    logic        b1_valid = 1'b0;
    logic        b1_restart = 1'b0;
    logic        r1_ready;
    logic        w1_en;
    logic [3:0]  w1_addr;
    logic [31:0] w1_data;
    logic        c1_rst;
    logic        d1_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel = 0;

    logic [35:0] exp_q[$];
    logic [7:0]  pend[$];
    int          widx = 0;

    imem_loader #(.ADDR_W(4), .WORD_COUNT(16)) dut (
        .CLK(clk), .RST(rst), .ByteIn(byte_in), .ByteValid(byte_valid),
        .ByteReady(byte_ready), .Restart(restart), .ImWrEn(im_wr_en),
        .ImWrAddr(im_wr_addr), .ImWrData(im_wr_data), .CpuRst(cpu_rst), .Done(done)
    );

    imem_loader #(.ADDR_W(4), .WORD_COUNT(1)) dut1 (
        .CLK(clk), .RST(rst), .ByteIn(b1_in), .ByteValid(b1_valid),
        .ByteReady(r1_ready), .Restart(b1_restart), .ImWrEn(w1_en),
        .ImWrAddr(w1_addr), .ImWrData(w1_data), .CpuRst(c1_rst), .Done(d1_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // reference model: every 4 accepted bytes form one big-endian word at the next index
    task automatic model_accept(input logic [7:0] b);
        logic [3:0] a;
        pend.push_back(b);
        if (pend.size() == 4) begin
            if (widx < 16) begin
                a = widx[3:0];
                exp_q.push_back({a, pend[0], pend[1], pend[2], pend[3]});
            end
            widx++;
            pend.delete();
        end
    endtask

    task automatic model_reset();
        pend.delete();
        widx = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (ok) model_accept(b);
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%02h not accepted within 50 cycles", b);
        end
    endtask

    task automatic idle_gap();
        if ($urandom_range(1, 0) == 1) begin
            repeat ($urandom_range(3, 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_cpurst_low"}, {31'd0, cpu_rst}, 32'd0);
        chk({tag, "_all_writes_seen"}, exp_q.size(), 32'd0);
    endtask

    // monitor: scores every write strobe and the ready/reset invariants
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst) begin
            if (im_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected",
                             im_wr_addr, im_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {28'd0, im_wr_addr}, {28'd0, e[35:32]});
                    chk("wr_data", im_wr_data, e[31:0]);
                end
            end
            chk("ready_only_in_load", {31'd0, byte_ready}, {31'd0, !(im_wr_en || done)});
            chk("cpurst_vs_done", {31'd0, cpu_rst}, {31'd0, !done});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        #1;
        chk("rst_ready", {31'd0, byte_ready}, 32'd1);
        chk("rst_wren", {31'd0, im_wr_en}, 32'd0);
        chk("rst_addr", {28'd0, im_wr_addr}, 32'd0);
        chk("rst_data", im_wr_data, 32'd0);
        chk("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);

        // continuous stream 0x00..0x3F: Done must rise right after edge 80
        do_reset();
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("cont_cycles_to_done", cyc - rel, 32'd80);
        wait_done("cont");

        // same data with random valid gaps
        do_reset();
        for (int i = 0; i < 64; i++) begin
            idle_gap();
            send_byte(8'(i));
        end
        wait_done("gaps");

        // restart from DONE, then a fresh random load
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        model_reset();
        chk("done_restart_cpurst", {31'd0, cpu_rst}, 32'd1);
        chk("done_restart_done", {31'd0, done}, 32'd0);
        chk("done_restart_ready", {31'd0, byte_ready}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            send_byte(b);
        end
        wait_done("reload");

        // restart after one word plus two bytes
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(i));
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        model_reset();
        for (int i = 0; i < 64; i++) send_byte(8'(8'h80 + i));
        wait_done("restart_mid");

        // asynchronous reset while word 5 is in its write cycle
        do_reset();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send_byte(b);
        end
        chk("pre_rst_wren", {31'd0, im_wr_en}, 32'd1);
        chk("pre_rst_pending", exp_q.size(), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_cpurst", {31'd0, cpu_rst}, 32'd1);
        chk("async_rst_wren", {31'd0, im_wr_en}, 32'd0);
        chk("async_rst_ready", {31'd0, byte_ready}, 32'd1);
        chk("async_rst_addr", {28'd0, im_wr_addr}, 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            idle_gap();
            b = 8'($urandom);
            send_byte(b);
        end
        wait_done("after_rst");

        // single-word build: DE AD BE EF
        @(posedge clk);
        #1;
        chk("w1_ready_idle", {31'd0, r1_ready}, 32'd1);
        b1_valid = 1'b1;
        b1_in = 8'hDE;
        @(posedge clk);
        #1;
        b1_in = 8'hAD;
        @(posedge clk);
        #1;
        b1_in = 8'hBE;
        @(posedge clk);
        #1;
        b1_in = 8'hEF;
        @(posedge clk);
        #1;
        b1_in = 8'h55;
        chk("w1_wren", {31'd0, w1_en}, 32'd1);
        chk("w1_addr", {28'd0, w1_addr}, 32'd0);
        chk("w1_data", w1_data, 32'hDEADBEEF);
        chk("w1_ready_in_write", {31'd0, r1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("w1_done", {31'd0, d1_done}, 32'd1);
        chk("w1_cpurst", {31'd0, c1_rst}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            b1_in = 8'($urandom);
            @(posedge clk);
            #1;
            chk("w1_no_more_writes", {31'd0, w1_en}, 32'd0);
            chk("w1_ready_low", {31'd0, r1_ready}, 32'd0);
            chk("w1_stays_done", {31'd0, d1_done}, 32'd1);
        end
        b1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
